// File: rtl/mem_sequencer.sv
// mem_sequencer: shares one sync RAM among fetch, data and, with MEM_SEQ_LOADER_EN defined, loader ports.
// Latency: req sampled in IDLE (N) -> ram_en N+1 -> read captured end of N+2 -> ack/rdata N+3; 4-cycle period.
// Backpressure: each requester holds req until its one-cycle ack; requests arriving while busy simply wait.
module mem_sequencer #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [15:0]       if_addr,
   output logic              if_ack,
   output logic [15:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [15:0]       d_addr,
   input  logic [15:0]       d_wdata,
   output logic              d_ack,
   output logic [15:0]       d_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [15:0]       ld_addr,
   input  logic [15:0]       ld_wdata,
   output logic              ld_ack,
   output logic [15:0]       ld_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   output logic              busy,
   output logic              err
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_LD} owner_t;

   state_t      state;
   owner_t      owner;
   logic        we_q;
   logic        oor_q;
   // 1 = data port was the most recent fetch/data grant, so fetch wins the next tie
   logic        rr_last_d;

   logic        ld_req_i;
   logic        any_req;
   owner_t      sel_owner;
   logic        sel_we;
   logic [15:0] sel_addr;
   logic [15:0] sel_wdata;
   logic        sel_oor;

`ifdef MEM_SEQ_LOADER_EN
   assign ld_req_i = ld_req;
`else
   // Loader port is inert in this build; fold its inputs away.
   logic ld_unused;
   assign ld_req_i  = 1'b0;
   assign ld_unused = ^{ld_req, ld_we, ld_addr, ld_wdata};
`endif

   assign any_req = ld_req_i | if_req | d_req;
   assign sel_oor = ({1'b0, sel_addr} >= 17'(DEPTH));

   // Choose the next owner: loader absolute priority, then fetch/data round-robin.
   always_comb begin
      sel_owner = OWN_D;
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
      if (ld_req_i) begin
         sel_owner = OWN_LD;
         sel_we    = ld_we;
         sel_addr  = ld_addr;
         sel_wdata = ld_wdata;
      end else if (if_req && (!d_req || rr_last_d)) begin
         sel_owner = OWN_IF;
         sel_we    = 1'b0;
         sel_addr  = if_addr;
         sel_wdata = 16'h0000;
      end
   end

   // Sequencer FSM; every output is registered and set up one state ahead.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         owner     <= OWN_D;
         we_q      <= 1'b0;
         oor_q     <= 1'b0;
         rr_last_d <= 1'b0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         ld_ack    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= 16'h0000;
         if_rdata  <= 16'h0000;
         d_rdata   <= 16'h0000;
         ld_rdata  <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner     <= sel_owner;
                  we_q      <= sel_we;
                  oor_q     <= sel_oor;
                  // out-of-range accesses never strobe the RAM
                  ram_en    <= !sel_oor;
                  ram_we    <= sel_we && !sel_oor;
                  ram_addr  <= sel_addr[ADDR_W-1:0];
                  ram_wdata <= sel_wdata;
                  busy      <= 1'b1;
                  state     <= S_ACCESS;
                  if (sel_owner == OWN_D)
                     rr_last_d <= 1'b1;
                  else if (sel_owner == OWN_IF)
                     rr_last_d <= 1'b0;
               end
            end
            S_ACCESS: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (!we_q) begin
                  case (owner)
                     OWN_IF:  if_rdata <= oor_q ? 16'h0000 : ram_rdata;
                     OWN_D:   d_rdata  <= oor_q ? 16'h0000 : ram_rdata;
                     default: ld_rdata <= oor_q ? 16'h0000 : ram_rdata;
                  endcase
               end
               if_ack <= (owner == OWN_IF);
               d_ack  <= (owner == OWN_D);
               ld_ack <= (owner == OWN_LD);
               err    <= oor_q;
               state  <= S_DONE;
            end
            default: begin
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
               ld_ack <= 1'b0;
               err    <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed tests of mem_sequencer against a transaction-level model and a sync RAM.
// Latency: model predicts grant at a sampling edge, RAM strobe +0, ack/rdata visible after edge +2.
// Backpressure: stimulus holds req until ack (or deliberately keeps it held for round-robin checks).
`timescale 1ns/1ps
module tb_mem_sequencer;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk;
   logic              reset;
   logic              if_req;
   logic [15:0]       if_addr;
   logic              if_ack;
   logic [15:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [15:0]       d_addr;
   logic [15:0]       d_wdata;
   logic              d_ack;
   logic [15:0]       d_rdata;
   logic              ld_req;
   logic              ld_we;
   logic [15:0]       ld_addr;
   logic [15:0]       ld_wdata;
   logic              ld_ack;
   logic [15:0]       ld_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_wdata;
   logic [15:0]       ram_rdata;
   logic              busy;
   logic              err;

   mem_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ack(ld_ack), .ld_rdata(ld_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] ram_mem [0:DEPTH-1];
   logic [15:0] ref_mem [0:DEPTH-1];

   // single-port synchronous RAM attached to the sequencer
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] = ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A grant happens at a sampling edge when no access is outstanding; the
   // access occupies that edge and the next three.
   int          edge_n = 0;
   bit          model_live = 0;
   bit          g_valid = 0;
   int          g_edge = 0;
   int          g_owner = 0;
   bit          g_we = 0;
   bit          g_oor = 0;
   logic [15:0] g_addr = 16'h0;
   logic [15:0] g_wdata = 16'h0;
   logic [15:0] g_rval = 16'h0;
   bit          m_last_d = 0;
   logic [15:0] e_rd [3];
   int          pick;

   always @(posedge clk) begin
      edge_n++;
      if (reset) begin
         model_live = 1;
         g_valid    = 0;
         m_last_d   = 0;
         for (int i = 0; i < 3; i++) e_rd[i] = 16'h0;
      end else if (model_live) begin
         if (g_valid && edge_n == g_edge + 2 && !g_we) e_rd[g_owner] = g_rval;
         if (!g_valid || edge_n >= g_edge + 4) begin
            pick = -1;
`ifdef MEM_SEQ_LOADER_EN
            if (ld_req) pick = 2;
`endif
            if (pick < 0) begin
               if (if_req && d_req) pick = m_last_d ? 0 : 1;
               else if (d_req)      pick = 1;
               else if (if_req)     pick = 0;
               if (pick == 1) m_last_d = 1;
               if (pick == 0) m_last_d = 0;
            end
            if (pick >= 0) begin
               g_valid = 1;
               g_edge  = edge_n;
               g_owner = pick;
               case (pick)
                  0:       begin g_we = 0;     g_addr = if_addr; g_wdata = 16'h0;    end
                  1:       begin g_we = d_we;  g_addr = d_addr;  g_wdata = d_wdata;  end
                  default: begin g_we = ld_we; g_addr = ld_addr; g_wdata = ld_wdata; end
               endcase
               g_oor  = (int'(g_addr) >= DEPTH);
               g_rval = g_oor ? 16'h0 : ref_mem[g_addr[8:0]];
               if (g_we && !g_oor) ref_mem[g_addr[8:0]] = g_wdata;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int en_cnt = 0;
   int ld_ack_cnt = 0;
   int md;
   bit x_busy, x_en, x_ack;

   always @(negedge clk) begin
      if (ram_en === 1'b1) en_cnt++;
      if (ld_ack === 1'b1) ld_ack_cnt++;
      if (model_live) begin
         md     = edge_n - g_edge;
         x_busy = g_valid && md >= 0 && md <= 2;
         x_en   = g_valid && md == 0 && !g_oor;
         x_ack  = g_valid && md == 2;
         chk1("busy", busy, x_busy);
         chk1("ram_en", ram_en, x_en);
         chk1("if_ack", if_ack, x_ack && g_owner == 0);
         chk1("d_ack", d_ack, x_ack && g_owner == 1);
         chk1("ld_ack", ld_ack, x_ack && g_owner == 2);
         chk1("err", err, x_ack && g_oor);
         chk16("if_rdata", if_rdata, e_rd[0]);
         chk16("d_rdata", d_rdata, e_rd[1]);
         chk16("ld_rdata", ld_rdata, e_rd[2]);
         if (x_en) begin
            chk16("ram_addr", 16'(ram_addr), 16'(g_addr[8:0]));
            chk1("ram_we", ram_we, g_we);
            if (g_we) chk16("ram_wdata", ram_wdata, g_wdata);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called and returns at posedge+1; lat counts cycles from the request cycle N.
   task automatic access(input int port, input logic we, input logic [15:0] a,
                         input logic [15:0] wd, output int lat,
                         output logic [15:0] rd, output logic e);
      lat = -1;
      rd  = 16'h0;
      e   = 1'b0;
      case (port)
         0:       begin if_req = 1; if_addr = a; end
         1:       begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
         default: begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = wd; end
      endcase
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (port == 0 && if_ack) begin rd = if_rdata; e = err; break; end
         if (port == 1 && d_ack)  begin rd = d_rdata;  e = err; break; end
         if (port == 2 && ld_ack) begin rd = ld_rdata; e = err; break; end
      end
      @(posedge clk);
      #1;
      if_req = 0;
      d_req  = 0;
      ld_req = 0;
   endtask

   int ack_port[$];
   int ack_cyc[$];

   task automatic watch(input int ncyc, input bit drop);
      ack_port.delete();
      ack_cyc.delete();
      for (int k = 0; k < ncyc; k++) begin
         logic di, dd, dl;
         @(negedge clk);
         di = if_ack; dd = d_ack; dl = ld_ack;
         if (di) begin ack_port.push_back(0); ack_cyc.push_back(k); end
         if (dd) begin ack_port.push_back(1); ack_cyc.push_back(k); end
         if (dl) begin ack_port.push_back(2); ack_cyc.push_back(k); end
         @(posedge clk);
         #1;
         if (drop) begin
            if (di) if_req = 0;
            if (dd) d_req = 0;
            if (dl) ld_req = 0;
         end
      end
   endtask

   task automatic chk_seq(input string nm, input int idx, input int port, input int cyc);
      if (ack_port.size() > idx) begin
         chk16({nm, "_port"}, 16'(ack_port[idx]), 16'(port));
         chk16({nm, "_cycle"}, 16'(ack_cyc[idx]), 16'(cyc));
      end else begin
         chk16({nm, "_missing"}, 16'(ack_port.size()), 16'(idx + 1));
      end
   endtask

   // watchdog: the run is tiny, so any hang is a fault
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

   int          lat;
   logic [15:0] rd;
   logic        e;
   int          en0;

   initial begin
      reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = 16'(i * 3) ^ 16'hC000;
         ref_mem[i] = 16'(i * 3) ^ 16'hC000;
      end
      ram_mem[5] = 16'hA1B2;
      ref_mem[5] = 16'hA1B2;

      // reset state
      do_reset();
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ram_en", ram_en, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk16("rst_ram_addr", 16'(ram_addr), 16'h0);
      chk16("rst_ram_wdata", ram_wdata, 16'h0);
      chk16("rst_if_rdata", if_rdata, 16'h0);
      chk16("rst_d_rdata", d_rdata, 16'h0);
      chk16("rst_ld_rdata", ld_rdata, 16'h0);
      @(posedge clk);
      #1;

      // single fetch
      access(0, 1'b0, 16'd5, 16'h0, lat, rd, e);
      chk16("fetch_latency", 16'(lat), 16'd3);
      chk16("fetch_rdata", rd, 16'hA1B2);
      chk1("fetch_err", e, 1'b0);

      // store then load
      access(1, 1'b1, 16'h0010, 16'hBEEF, lat, rd, e);
      chk16("store_latency", 16'(lat), 16'd3);
      chk1("store_err", e, 1'b0);
      access(1, 1'b0, 16'h0010, 16'h0, lat, rd, e);
      chk16("load_rdata", rd, 16'hBEEF);
      chk16("load_if_rdata_kept", if_rdata, 16'hA1B2);

      // out of range load and store
      en0 = en_cnt;
      access(1, 1'b0, 16'h0200, 16'h0, lat, rd, e);
      chk1("oor_load_err", e, 1'b1);
      chk16("oor_load_rdata", rd, 16'h0);
      access(1, 1'b1, 16'h0200, 16'h1234, lat, rd, e);
      chk1("oor_store_err", e, 1'b1);
      chk16("oor_ram_en_count", 16'(en_cnt - en0), 16'd0);
      chk16("oor_mem0_kept", ram_mem[0], 16'hC000);

      // tie after reset, both held continuously: d, if, d, if
      do_reset();
      if_req = 1; if_addr = 16'd5;
      d_req = 1; d_we = 0; d_addr = 16'h0010;
      watch(16, 1'b0);
      if_req = 0; d_req = 0;
      chk16("tie_count", 16'(ack_port.size()), 16'd4);
      chk_seq("tie0", 0, 1, 3);
      chk_seq("tie1", 1, 0, 7);
      chk_seq("tie2", 2, 1, 11);
      chk_seq("tie3", 3, 0, 15);

      // loader with simultaneous fetch and data requests
      do_reset();
      ld_req = 1; ld_we = 0; ld_addr = 16'd5;
      d_req = 1; d_we = 0; d_addr = 16'h0010;
      if_req = 1; if_addr = 16'd5;
      watch(12, 1'b1);
      ld_req = 0; d_req = 0; if_req = 0;
`ifdef MEM_SEQ_LOADER_EN
      chk16("ld_count", 16'(ack_port.size()), 16'd3);
      chk_seq("ld0", 0, 2, 3);
      chk_seq("ld1", 1, 1, 7);
      chk_seq("ld2", 2, 0, 11);
      chk16("ld_rdata", ld_rdata, 16'hA1B2);
`else
      chk16("ld_count", 16'(ack_port.size()), 16'd2);
      chk_seq("ld0", 0, 1, 3);
      chk_seq("ld1", 1, 0, 7);
      chk16("ld_ack_never", 16'(ld_ack_cnt), 16'd0);
      chk16("ld_rdata_zero", ld_rdata, 16'h0);
`endif

      // reset during WAIT
      access(1, 1'b0, 16'h0010, 16'h0, lat, rd, e);
      chk16("pre_rst_d_rdata", rd, 16'hBEEF);
      if_req = 1; if_addr = 16'd6;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1; if_req = 0;
      @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_if_ack", if_ack, 1'b0);
      chk16("midrst_if_rdata", if_rdata, 16'h0);
      chk16("midrst_d_rdata", d_rdata, 16'h0);
      @(posedge clk);
      #1;
      access(0, 1'b0, 16'd5, 16'h0, lat, rd, e);
      chk16("post_rst_latency", 16'(lat), 16'd3);
      chk16("post_rst_rdata", rd, 16'hA1B2);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Single-clock arbiter and sequencer for the shared 16-bit unified memory of the RiSC-16 system. It replaces the derived two-phase fetch/execute clocking with request/acknowledge ports on one clock domain. It shares one single-port synchronous RAM among three requesters: the CPU instruction-fetch port, the CPU data port, and an optional external loader port. It sits between the CPU and the RAM in the top level.

## Interface
- DEPTH, 512, number of implemented 16-bit RAM words
- ADDR_W, 9, RAM address width; DEPTH <= 2**ADDR_W
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  16  fetch word address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  16  fetched instruction; holds last value
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data word address
- d_wdata  in  16  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  16  load result; holds last value
- ld_req, ld_we, ld_addr[15:0], ld_wdata[15:0]  in  loader request, same semantics as data port
- ld_ack  out  1, ld_rdata  out  16  loader completion and read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable, valid only with ram_en
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid one cycle after the ram_en cycle
- busy  out  1  high whenever state != IDLE
- err  out  1  pulses with ack when the completed access was out of range

## Operation
- The FSM has four states: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. Each state lasts one cycle, except IDLE, which waits for a request.
- In IDLE, with any request present:
  - Latch the owner, address, we and wdata.
  - Transition to ACCESS.
- Arbitration:
  - The loader has absolute priority.
  - Between fetch and data, round-robin: on a tie, grant the port not granted most recently.
  - The round-robin pointer updates only on fetch or data grants.
  - After reset, data wins the first tie.
- ACCESS:
  - ram_en = 1, ram_we = latched we, ram_addr = latched addr[ADDR_W-1:0], ram_wdata = latched wdata.
  - Fetch is always a read.
- WAIT:
  - For a read, capture ram_rdata into the owner's rdata register at the end of the cycle.
  - The other ports' rdata registers are unchanged.
- DONE: assert exactly one ack, the owner's, for one cycle. err = 1 if the access was out of range.
- Out of range means latched addr >= DEPTH. In that case:
  - ram_en stays 0 in ACCESS (no RAM write).
  - A read loads 16'h0000 into the owner's rdata.
  - err pulses in DONE.
- Requests are sampled only in IDLE. A requester that drops req before its ack still gets the access completed and acked.
- Reset values: all acks, err, busy, ram_en, ram_we = 0; ram_addr, ram_wdata, all rdata = 0; state = IDLE; round-robin pointer favours data.

## Timing
- req high in IDLE cycle N -> ram_en in N+1 -> ram_rdata sampled at end of N+2 -> ack and valid rdata in N+3. Writes land in RAM at the end of N+1.
- The earliest next grant is N+4, so the minimum access period is 4 cycles. A requester registering req low after seeing ack is correctly not re-granted.
- Requests arriving while busy wait; none are lost, provided req is held.
- Reset asserted in any cycle forces IDLE on the next edge with no ack.
  - If reset coincides with ACCESS, that cycle's RAM write still occurs.
- Simultaneous loader, fetch and data requests: loader first. Then the round-robin winner, then the other, as each returns to IDLE.

## Configuration
- MEM_SEQ_LOADER_EN:
  - Defined: the loader port is arbitrated as described.
  - Undefined: ld_* inputs are ignored, ld_ack = 0, ld_rdata = 0, and arbitration is fetch/data round-robin only.

## Test plan
- Single fetch: mem[5] = 16'hA1B2, if_req with if_addr = 5 at cycle N -> if_ack in N+3 only, if_rdata = 16'hA1B2, err = 0.
- Store then load: d_we = 1, addr 16'h0010, wdata 16'hBEEF, then a load of 16'h0010 -> second d_ack gives d_rdata = 16'hBEEF; if_rdata unchanged.
- Tie after reset: if_req and d_req both held -> d_ack first, if_ack 4 cycles later; with both held continuously, grants alternate d, if, d, if.
- Out of range: DEPTH = 512, load from 16'h0200 -> d_ack with err = 1 and d_rdata = 0, ram_en never asserted. A store to 16'h0200 leaves mem[0] unchanged.
- Loader priority (macro defined): ld_req, d_req, if_req all high in the same cycle -> ld_ack first; the round-robin pointer is unaffected. With the macro undefined, ld_ack never asserts.
- Reset mid-access: reset pulsed during WAIT -> no ack, busy = 0 next cycle, all rdata = 0; a subsequent fetch completes normally in 4 cycles.
